// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings for the I/D cache backing-memory arbiter: load/store modes,
// sequencer states and the captured-transaction control word.
package cache_mem_arbiter_pkg;

    localparam logic [2:0] B_MODE  = 3'b000;
    localparam logic [2:0] H_MODE  = 3'b001;
    localparam logic [2:0] W_MODE  = 3'b010;
    localparam logic [2:0] UB_MODE = 3'b100;
    localparam logic [2:0] UH_MODE = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    typedef struct packed {
        src_t       src;
        logic       we;
        logic [2:0] ls_mode;
        logic       err;
    } op_t;

    // Byte accesses never fault; halfwords need even, words need 4-byte alignment.
    function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (mode)
            W_MODE:          mis = (addr_lo != 2'b00);
            H_MODE, UH_MODE: mis = addr_lo[0];
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr.sv
// Two-way round-robin tie-break between the I and D requesters.
// Latency: grant is combinational; last_grant updates on the accept edge.
// Backpressure: none of its own; the caller qualifies grants with its idle state.
module rr_arbiter2
    import cache_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic accept,
    output logic grant_i,
    output logic grant_d
);

    src_t last_grant;

    // On a tie the side that did not win last time gets the port.
    always_comb begin
        grant_d = req_d && (!req_i || (last_grant == SRC_I));
        grant_i = req_i && !grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= SRC_I;
        end else if (accept) begin
            last_grant <= grant_d ? SRC_D : SRC_I;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one backing-memory port between I-side and D-side cache refill/write paths.
// Latency: accept N, mem request N+1, response no earlier than N+3 (misaligned D reject at N+1).
// Backpressure: requester ready only in IDLE; payload held stable until mem_req_ready.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_we,
    input  logic [2:0]            d_ls_mode,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [2:0]            mem_ls_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,

    output logic                  busy
);

    state_t                state;
    state_t                state_nxt;
    op_t                   cap_op;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [DATA_WIDTH-1:0] cap_data;

    logic grant_i;
    logic grant_d;
    logic accept;
    logic d_misaligned;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (i_req_valid),
        .req_d   (d_req_valid),
        .accept  (accept),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    assign accept       = (state == ST_IDLE) && (grant_i || grant_d);
    assign d_misaligned = is_misaligned(d_ls_mode, d_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (grant_d && d_misaligned) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: if (mem_req_ready)  state_nxt = ST_WAIT;
            ST_WAIT:  if (mem_resp_valid) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The I side is read-only, so its capture forces a plain word read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_op    <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_data  <= '0;
        end else if (accept) begin
            cap_data <= '0;
            if (grant_d) begin
                cap_op    <= '{src: SRC_D, we: d_we, ls_mode: d_ls_mode, err: d_misaligned};
                cap_addr  <= d_addr;
                cap_wdata <= d_wdata;
            end else begin
                cap_op    <= '{src: SRC_I, we: 1'b0, ls_mode: W_MODE, err: 1'b0};
                cap_addr  <= i_addr;
                cap_wdata <= '0;
            end
        end else if ((state == ST_WAIT) && mem_resp_valid) begin
            cap_data <= mem_resp_data;
        end
    end

    always_comb begin
        i_req_ready   = (state == ST_IDLE) && grant_i;
        d_req_ready   = (state == ST_IDLE) && grant_d;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_ls_mode   = 3'b000;
        mem_addr      = '0;
        mem_wdata     = '0;
        i_resp_valid  = 1'b0;
        i_resp_data   = '0;
        d_resp_valid  = 1'b0;
        d_resp_data   = '0;
        d_resp_err    = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                mem_we        = cap_op.we;
                mem_ls_mode   = cap_op.ls_mode;
                mem_addr      = cap_addr;
                mem_wdata     = cap_wdata;
            end
            ST_RESP: begin
                if (cap_op.src == SRC_D) begin
                    d_resp_valid = 1'b1;
                    d_resp_data  = cap_data;
                    d_resp_err   = cap_op.err;
                end else begin
                    i_resp_valid = 1'b1;
                    i_resp_data  = cap_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference memory.
`timescale 1ns/1ps
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_ready;
    logic [31:0] i_addr;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        d_req_valid, d_req_ready, d_we;
    logic [2:0]  d_ls_mode;
    logic [31:0] d_addr, d_wdata;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [2:0]  mem_ls_mode;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
        .d_ls_mode(d_ls_mode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_ls_mode(mem_ls_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    logic [138:0] all_out;
    assign all_out = {i_req_ready, d_req_ready, i_resp_valid, i_resp_data, d_resp_valid,
                      d_resp_data, d_resp_err, mem_req_valid, mem_we, mem_ls_mode,
                      mem_addr, mem_wdata, busy};

    int errors = 0;
    int checks = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    int mem_vld_cycles = 0;
    int hs_cnt = 0;

    int resp_delay = 0;
    int stall_cycles = 0;
    bit rand_ready = 1'b0;
    bit stray_req = 1'b0;

    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];
    logic        hs_we;
    logic [2:0]  hs_mode;
    logic [31:0] hs_addr;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(negedge clk) begin
        if (i_resp_valid)  i_pulses++;
        if (d_resp_valid)  d_pulses++;
        if (mem_req_valid) mem_vld_cycles++;
    end

    // Backing-memory model: accepts handshakes, answers resp_delay cycles into WAIT.
    initial begin : mem_side
        bit          pending;
        int          cnt;
        logic [31:0] pdata;
        pending = 1'b0;
        cnt = 0;
        pdata = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
            end else if (mem_req_valid && mem_req_ready) begin
                hs_cnt++;
                hs_we   = mem_we;
                hs_mode = mem_ls_mode;
                hs_addr = mem_addr;
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                pdata   = mem_store.exists(mem_addr) ? mem_store[mem_addr] : mem_init(mem_addr);
                pending = 1'b1;
                cnt     = resp_delay;
            end
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (stray_req) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hBAD0_BAD0;
                stray_req      = 1'b0;
            end else if (pending && rst_n) begin
                if (cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = pdata;
                    pending        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (stall_cycles > 0) begin
                mem_req_ready = 1'b0;
                stall_cycles--;
            end else begin
                mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected response straight from the alignment rules and a flat word memory.
    function automatic void model(input bit side, input logic we, input logic [2:0] mode,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] exp_data, output logic exp_err);
        logic mis;
        mis = side && (((mode == W_MODE) && (addr % 4 != 0)) ||
                       (((mode == H_MODE) || (mode == UH_MODE)) && (addr % 2 != 0)));
        exp_err = mis;
        if (mis) begin
            exp_data = '0;
        end else if (side && we) begin
            ref_mem[addr] = wdata;
            exp_data = wdata;
        end else begin
            exp_data = ref_mem.exists(addr) ? ref_mem[addr] : mem_init(addr);
        end
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        i_req_valid = 1'b0; i_addr = '0;
        d_req_valid = 1'b0; d_we = 1'b0; d_ls_mode = W_MODE; d_addr = '0; d_wdata = '0;
        stall_cycles = 0; stray_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue(input bit side, input logic we, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata, output bit ok);
        ok = 1'b0;
        if (side) begin
            d_req_valid = 1'b1; d_we = we; d_ls_mode = mode; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req_valid = 1'b1; i_addr = addr;
        end
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = side ? d_req_ready : i_req_ready;
            @(posedge clk);
            #1;
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input bit side, output logic [31:0] data, output logic err,
                             output int cycles, output logic first_vld);
        cycles = -1; data = '0; err = 1'b0; first_vld = 1'b0;
        for (int c = 1; c <= 200 && cycles < 0; c++) begin
            @(negedge clk);
            if (c == 1) first_vld = mem_req_valid;
            if (side ? d_resp_valid : i_resp_valid) begin
                cycles = c;
                data   = side ? d_resp_data : i_resp_data;
                err    = side ? d_resp_err : 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input bit side, input logic we, input logic [2:0] mode,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output bit ok, output logic [31:0] data, output logic err,
                           output int cycles, output logic first_vld, output int hs_delta);
        int hs0;
        hs0 = hs_cnt;
        issue(side, we, mode, addr, wdata, ok);
        wait_resp(side, data, err, cycles, first_vld);
        hs_delta = hs_cnt - hs0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        apply_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_idle_outputs: got %h expected 0", all_out); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_d_read();
        bit ok; logic [31:0] data; logic err; int cyc; logic fv; int hd; int ip0, dp0;
        rand_ready = 1'b0; resp_delay = 2;
        mem_store[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100]   = 32'hDEADBEEF;
        ip0 = i_pulses; dp0 = d_pulses;
        run_txn(1'b1, 1'b0, W_MODE, 32'h100, 32'h0, ok, data, err, cyc, fv, hd);
        checks++;
        if (!ok || cyc < 0) begin errors++; $display("FAIL d_read_handshake: accepted=%0d cycles=%0d expected accepted and response", ok, cyc); end
        checks++;
        if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL d_read_data: got %h expected deadbeef", data); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL d_read_err: got %b expected 0", err); end
        checks++;
        if ((d_pulses - dp0) != 1 || (i_pulses - ip0) != 0) begin
            errors++; $display("FAIL d_read_pulses: d=%0d i=%0d expected d=1 i=0", d_pulses - dp0, i_pulses - ip0);
        end
    endtask

    task automatic test_timing();
        bit ok; logic [31:0] data; logic err; int cyc; logic fv; int hd;
        logic [31:0] exp_d; logic exp_e;
        rand_ready = 1'b0; resp_delay = 0;
        model(1'b1, 1'b0, W_MODE, 32'h104, 32'h0, exp_d, exp_e);
        run_txn(1'b1, 1'b0, W_MODE, 32'h104, 32'h0, ok, data, err, cyc, fv, hd);
        checks++;
        if (fv !== 1'b1) begin errors++; $display("FAIL timing_mem_req_n1: got %b expected 1", fv); end
        checks++;
        if (cyc != 3) begin errors++; $display("FAIL timing_resp_n3: got cycle %0d expected 3", cyc); end
        checks++;
        if (data !== exp_d) begin errors++; $display("FAIL timing_data: got %h expected %h", data, exp_d); end
        d_req_valid = 1'b1; d_we = 1'b0; d_ls_mode = W_MODE; d_addr = 32'h108;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || d_req_ready !== 1'b1) begin
            errors++; $display("FAIL timing_accept_n4: busy=%b ready=%b expected busy=0 ready=1", busy, d_req_ready);
        end
        d_req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_tie();
        bit both_rdy; bit acc_i; bit acc_d; int order[$];
        apply_reset();
        rand_ready = 1'b0; resp_delay = 1;
        for (int r = 0; r < 2; r++) begin
            order.delete();
            both_rdy = 1'b0;
            i_addr = 32'h40; d_addr = 32'h80; d_we = 1'b0; d_ls_mode = W_MODE;
            i_req_valid = 1'b1; d_req_valid = 1'b1;
            for (int k = 0; k < 200 && order.size() < 2; k++) begin
                @(negedge clk);
                if (i_req_ready && d_req_ready) both_rdy = 1'b1;
                acc_i = i_req_ready; acc_d = d_req_ready;
                @(posedge clk);
                #1;
                if (acc_d) begin order.push_back(1); d_req_valid = 1'b0; end
                if (acc_i) begin order.push_back(0); i_req_valid = 1'b0; end
            end
            i_req_valid = 1'b0; d_req_valid = 1'b0;
            for (int k = 0; k < 50 && busy; k++) @(posedge clk);
            #1;
            checks++;
            if (order.size() != 2) begin
                errors++; $display("FAIL tie_round%0d_count: got %0d acceptances expected 2", r, order.size());
            end else begin
                checks++;
                if (order[0] != 1 || order[1] != 0) begin
                    errors++; $display("FAIL tie_round%0d_order: got %0d,%0d expected D(1),I(0)", r, order[0], order[1]);
                end
            end
            checks++;
            if (both_rdy) begin errors++; $display("FAIL tie_round%0d_ready: got both ready expected one", r); end
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  tm [7] = '{W_MODE, H_MODE, UH_MODE, B_MODE, UB_MODE, H_MODE, W_MODE};
        logic [31:0] ta [7] = '{32'h102, 32'h101, 32'h203, 32'h103, 32'h301, 32'h102, 32'h104};
        logic        te [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bit ok; logic [31:0] data; logic err; int cyc; logic fv; int hd; int mv0;
        rand_ready = 1'b0; resp_delay = 0;
        for (int k = 0; k < 7; k++) begin
            mv0 = mem_vld_cycles;
            run_txn(1'b1, (k == 0) ? 1'b1 : 1'b0, tm[k], ta[k], 32'hCAFE_0000 + k, ok, data, err, cyc, fv, hd);
            checks++;
            if (err !== te[k]) begin errors++; $display("FAIL misalign%0d_err: got %b expected %b", k, err, te[k]); end
            checks++;
            if (hd != (te[k] ? 0 : 1)) begin errors++; $display("FAIL misalign%0d_mem_hs: got %0d expected %0d", k, hd, te[k] ? 0 : 1); end
            checks++;
            if (cyc != (te[k] ? 1 : 3)) begin errors++; $display("FAIL misalign%0d_latency: got %0d expected %0d", k, cyc, te[k] ? 1 : 3); end
            if (te[k]) begin
                checks++;
                if (data !== 32'h0 || mem_vld_cycles != mv0) begin
                    errors++; $display("FAIL misalign%0d_quiet: data=%h mem_vld_cycles=%0d expected data=0 cycles=0", k, data, mem_vld_cycles - mv0);
                end
            end else begin
                ref_mem[ta[k]] = data;
            end
        end
    endtask

    task automatic test_stall();
        bit ok; logic [31:0] data; logic err; int cyc; logic fv; int hs0; int vcyc; bit unstable; bit seen;
        rand_ready = 1'b0; resp_delay = 1;
        hs0 = hs_cnt; vcyc = 0; unstable = 1'b0; seen = 1'b0;
        stall_cycles = 6;
        issue(1'b1, 1'b1, W_MODE, 32'h200, 32'h1234_5678, ok);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                seen = 1'b1;
                vcyc++;
                if (mem_we !== 1'b1 || mem_ls_mode !== W_MODE || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678)
                    unstable = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        wait_resp(1'b1, data, err, cyc, fv);
        ref_mem[32'h200] = 32'h1234_5678;
        checks++;
        if (vcyc < 5) begin errors++; $display("FAIL stall_valid_cycles: got %0d expected >=5", vcyc); end
        checks++;
        if (unstable) begin errors++; $display("FAIL stall_payload: got changing payload expected stable we=1 addr=200 data=12345678"); end
        checks++;
        if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL stall_handshakes: got %0d expected 1", hs_cnt - hs0); end
        checks++;
        if (data !== 32'h1234_5678 || err !== 1'b0) begin errors++; $display("FAIL stall_ack: got %h/%b expected 12345678/0", data, err); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [31:0] data; logic err; int cyc; logic fv; int hd; int ip0, dp0;
        logic [31:0] exp_d; logic exp_e;
        rand_ready = 1'b0; resp_delay = 50;
        issue(1'b1, 1'b0, W_MODE, 32'h300, 32'h0, ok);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_wait: busy=%b mem_req_valid=%b expected 1/0", busy, mem_req_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", all_out); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        resp_delay = 0;
        ip0 = i_pulses; dp0 = d_pulses;
        stray_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ((i_pulses - ip0) != 0 || (d_pulses - dp0) != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_stray: i=%0d d=%0d busy=%b expected 0/0/0", i_pulses - ip0, d_pulses - dp0, busy);
        end
        model(1'b0, 1'b0, W_MODE, 32'h40, 32'h0, exp_d, exp_e);
        run_txn(1'b0, 1'b0, W_MODE, 32'h40, 32'h0, ok, data, err, cyc, fv, hd);
        checks++;
        if (data !== exp_d || cyc != 3) begin errors++; $display("FAIL rstmid_iread: got %h at %0d expected %h at 3", data, cyc, exp_d); end
        checks++;
        if (hs_we !== 1'b0 || hs_mode !== W_MODE || hs_addr !== 32'h40) begin
            errors++; $display("FAIL rstmid_ipayload: got we=%b mode=%b addr=%h expected 0/%b/40", hs_we, hs_mode, hs_addr, W_MODE);
        end
    endtask

    task automatic test_idle_stray();
        int ip0, dp0; bit was_busy;
        ip0 = i_pulses; dp0 = d_pulses; was_busy = 1'b0;
        stray_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy) was_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if ((i_pulses - ip0) != 0 || (d_pulses - dp0) != 0 || was_busy) begin
            errors++; $display("FAIL idle_stray: i=%0d d=%0d busy=%b expected 0/0/0", i_pulses - ip0, d_pulses - dp0, was_busy);
        end
    endtask

    task automatic test_random();
        logic [2:0] mtab [5] = '{W_MODE, H_MODE, UH_MODE, B_MODE, UB_MODE};
        bit ok; logic [31:0] data; logic err; int cyc; logic fv; int hd;
        bit side; logic we; logic [2:0] mode; logic [31:0] addr, wdata, exp_d; logic exp_e;
        rand_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            side  = 1'($urandom_range(0, 1));
            we    = side ? 1'($urandom_range(0, 1)) : 1'b0;
            mode  = side ? mtab[$urandom_range(0, 4)] : W_MODE;
            addr  = 32'($urandom_range(0, 63));
            wdata = $urandom;
            resp_delay = $urandom_range(0, 3);
            model(side, we, mode, addr, wdata, exp_d, exp_e);
            run_txn(side, we, mode, addr, wdata, ok, data, err, cyc, fv, hd);
            checks++;
            if (!ok || cyc < 0 || data !== exp_d || err !== exp_e) begin
                errors++;
                $display("FAIL rand%0d_resp: side=%0d addr=%h got %h/%b (cyc %0d) expected %h/%b", t, side, addr, data, err, cyc, exp_d, exp_e);
            end
            checks++;
            if (hd != (exp_e ? 0 : 1)) begin errors++; $display("FAIL rand%0d_mem_hs: got %0d expected %0d", t, hd, exp_e ? 0 : 1); end
            if (!side) begin
                checks++;
                if (hs_we !== 1'b0 || hs_mode !== W_MODE || hs_addr !== addr) begin
                    errors++; $display("FAIL rand%0d_ipayload: got we=%b mode=%b addr=%h expected 0/%b/%h", t, hs_we, hs_mode, hs_addr, W_MODE, addr);
                end
            end
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_d_read();
        test_timing();
        test_misaligned();
        test_stall();
        test_reset_mid();
        test_idle_stray();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single backing-memory port between the instruction-side and data-side cache refill/write paths. Each requester issues one transaction at a time via a valid/ready request and a one-cycle response pulse. The block runs a four-state sequencer, applies round-robin arbitration on ties, and rejects misaligned data-side accesses without touching memory.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req_valid / i_req_ready  in/out  1  I-side request handshake (read-only, always W_MODE)
- i_addr  in  ADDR_WIDTH  I-side address
- i_resp_valid  out  1  one-cycle I-side response pulse
- i_resp_data  out  DATA_WIDTH  I-side read data
- d_req_valid / d_req_ready  in/out  1  D-side request handshake
- d_we  in  1  D-side write
- d_ls_mode  in  3  W/H/UH/B/UB mode
- d_addr  in  ADDR_WIDTH  D-side address
- d_wdata  in  DATA_WIDTH  D-side write data
- d_resp_valid  out  1  one-cycle D-side response pulse
- d_resp_data  out  DATA_WIDTH  read data (write ack: memory value)
- d_resp_err  out  1  misaligned access, valid with d_resp_valid
- mem_req_valid / mem_req_ready  out/in  1  memory request handshake
- mem_we, mem_ls_mode, mem_addr, mem_wdata  out  1/3/ADDR_WIDTH/DATA_WIDTH  memory request payload
- mem_resp_valid  in  1  memory response/ack (reads and writes)
- mem_resp_data  in  DATA_WIDTH  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is computed combinationally.
  - Only one requester valid: grant it.
  - Both valid: grant the one not in last_grant.
  - i_req_ready = IDLE && grant_i; d_req_ready = IDLE && grant_d.
  - On acceptance: capture the source, address, we, ls_mode and wdata; update last_grant.
  - Aligned → ISSUE. Misaligned D (W with addr[1:0]≠0; H/UH with addr[0]=1) → RESP with err=1 and data=0.
- ISSUE: mem_req_valid=1 with the captured payload, held stable until mem_req_ready. I-side drives mem_we=0, mem_ls_mode=W_MODE. On handshake → WAIT.
- WAIT: on mem_resp_valid, capture mem_resp_data → RESP. No timeout; waits indefinitely.
- RESP: assert the captured source's resp_valid for exactly one cycle with the registered data/err → IDLE.
- mem_resp_valid is ignored in every state except WAIT.
- Requests are never accepted outside IDLE. Ready stays low there; a held valid is serviced later.
- Reset values:
  - state = IDLE; last_grant = I, so D wins the first tie.
  - All outputs 0, all capture registers 0.

## Timing
- Acceptance at edge N; mem_req_valid high in cycle N+1.
- With mem_req_ready=1 and mem_resp_valid in the first WAIT cycle:
  - resp_valid in cycle N+3.
  - Next acceptance possible in cycle N+4 (4-cycle minimum occupancy).
- Misaligned reject: resp_valid/err in cycle N+1; no mem_req_valid at any point.
- Ready and resp signals:
  - ready is combinational from state and grant; requester valid must not depend on ready.
  - resp outputs are registered.
- Reset mid-operation:
  - Asynchronous return to IDLE with all outputs 0; the in-flight transaction is abandoned.
  - A stale mem_resp_valid after reset lands in IDLE and is ignored.
  - The memory side must tolerate abandoned requests.
- Simultaneous new request and response: impossible by construction; ready is low in RESP.

## Structure
- Shared defines/package holds W_MODE, H_MODE, UH_MODE, B_MODE, UB_MODE (same encoding the data cache uses) and the state enum typedef.
- Natural sub-module: rr_arbiter2. Contains the last_grant flop, the two-request tie-break and the accept-driven update. The FSM, capture registers and alignment check live in the top.

## Test plan
- D read, d_addr=0x100, mem_resp 3 cycles after issue with 0xDEADBEEF → one d_resp_valid pulse, data 0xDEADBEEF, err=0; i_resp_valid stays 0.
- I and D both valid after reset, held for two transactions → D served first, I second. Repeat with both valid again → D then I (strict alternation).
- D W_MODE write at 0x102 → d_resp_valid with err=1 one cycle after accept; mem_req_valid never asserts.
- mem_req_ready held low 5 cycles in ISSUE → mem_req_valid and payload stable throughout; exactly one handshake.
- rst_n low during WAIT, then a stray mem_resp_valid → all outputs 0 immediately and the stray response is ignored. A following I read at 0x40 completes normally.
- mem_resp_valid pulsed while IDLE with no request → no resp_valid on either side; state stays IDLE.
